inst_queue: RTL and testbench

- Instruction FIFO between instruction fetch and decode/dispatch.
- Accepts one fetched instruction plus its PC per cycle from fetch, and presents the oldest entry show-ahead to dispatch.
- Drives the full flag that fetch uses to gate ICache requests; the flag carries enough slack to absorb requests already in flight.
- Flushed completely on a ROB refresh (mispredict/redirect).

---
 rtl/inst_queue_pkg.sv | 17 +
 rtl/inst_queue_if.sv | 24 ++
 rtl/inst_queue_ram.sv | 24 ++
 rtl/inst_queue.sv | 76 +++++++
 tb/tb_inst_queue.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/inst_queue_pkg.sv
// Shared widths, queue sizing defaults and the queue entry layout.
// Pure declarations: no logic, so no latency and no backpressure.
package inst_queue_pkg;
    localparam int INST_WIDTH     = 32;
    localparam int ADDR_WIDTH     = 32;
    localparam int IQ_DEPTH       = 16;
    localparam int IQ_PTR_WIDTH   = 4;
    localparam int IQ_FULL_MARGIN = 2;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [ADDR_WIDTH-1:0] pc;
    } iq_entry_t;
endpackage

// File: rtl/inst_queue_if.sv
// Fetch-side push and dispatch-side head signals of the instruction queue.
// master = fetch/dispatch environment, slave = the queue; full flag is fetch's only backpressure.
interface inst_queue_if;
    import inst_queue_pkg::*;

    logic                  rdy_inst_if_in;
    logic [INST_WIDTH-1:0] inst_if_in;
    logic [ADDR_WIDTH-1:0] pc_if_in;
    logic                  iq_full_iq_out;
    logic                  valid_dp_out;
    logic [INST_WIDTH-1:0] inst_dp_out;
    logic [ADDR_WIDTH-1:0] pc_dp_out;
    logic                  pop_dp_in;

    modport master (
        output rdy_inst_if_in, inst_if_in, pc_if_in, pop_dp_in,
        input  iq_full_iq_out, valid_dp_out, inst_dp_out, pc_dp_out
    );

    modport slave (
        input  rdy_inst_if_in, inst_if_in, pc_if_in, pop_dp_in,
        output iq_full_iq_out, valid_dp_out, inst_dp_out, pc_dp_out
    );
endinterface

// File: rtl/inst_queue_ram.sv
// Entry storage: one synchronous write port, one asynchronous read port.
// Write lands on the clock edge, read is combinational; no backpressure of its own.
module inst_queue_ram #(
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = 4,
    parameter int WIDTH     = 64
) (
    input  logic                 clk_in,
    input  logic                 i_wr_en,
    input  logic [PTR_WIDTH-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]     i_wr_dat,
    input  logic [PTR_WIDTH-1:0] i_rd_addr,
    output logic [WIDTH-1:0]     o_rd_dat
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    assign o_rd_dat = r_mem[i_rd_addr];
endmodule

// File: rtl/inst_queue.sv
// Fetch-to-dispatch instruction FIFO with show-ahead head; a push is visible one cycle later.
// Full asserts FULL_MARGIN entries early to absorb in-flight fetches; refresh flushes everything.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH       = IQ_DEPTH,
    parameter int PTR_WIDTH   = IQ_PTR_WIDTH,
    parameter int FULL_MARGIN = IQ_FULL_MARGIN
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    input  logic         refresh_rob_cdb_in,
    inst_queue_if.slave  iq
);
    localparam logic [PTR_WIDTH:0] L_DEPTH   = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] L_FULL_TH = (PTR_WIDTH+1)'(DEPTH - FULL_MARGIN);

    logic [PTR_WIDTH-1:0] r_head;
    logic [PTR_WIDTH-1:0] r_tail;
    logic [PTR_WIDTH:0]   r_count;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_wr_en;
    logic                 w_valid;
    logic [PTR_WIDTH:0]   w_count_next;
    iq_entry_t            w_head_ent;

    assign w_push       = iq.rdy_inst_if_in && (r_count != L_DEPTH);
    assign w_pop        = iq.pop_dp_in && (r_count != '0);
    assign w_count_next = r_count + (PTR_WIDTH+1)'(w_push) - (PTR_WIDTH+1)'(w_pop);

    // Array write must follow the same priority as the pointers so a stalled or flushed push never lands.
    assign w_wr_en = !rst_in && rdy_in && !refresh_rob_cdb_in && w_push;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (refresh_rob_cdb_in && rdy_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy_in) begin
            if (w_push) begin
                r_tail <= r_tail + PTR_WIDTH'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_WIDTH'(1);
            end
            r_count <= w_count_next;
        end
    end

    inst_queue_ram #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH),
        .WIDTH     ($bits(iq_entry_t))
    ) u_ram (
        .clk_in    (clk_in),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_tail),
        .i_wr_dat  ({iq.inst_if_in, iq.pc_if_in}),
        .i_rd_addr (r_head),
        .o_rd_dat  (w_head_ent)
    );

    // Full depends on the count register alone: fetch closes a combinational loop through it otherwise.
    assign w_valid           = (r_count != '0);
    assign iq.valid_dp_out   = w_valid;
    assign iq.iq_full_iq_out = (r_count >= L_FULL_TH) ? TRUE : FALSE;
    assign iq.inst_dp_out    = w_valid ? w_head_ent.inst : '0;
    assign iq.pc_dp_out      = w_valid ? w_head_ent.pc   : '0;
endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: a queue-based reference model tracks expected contents,
// and a negedge monitor compares the DUT head/valid/full against it every cycle.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH       = 16;
    localparam int FULL_MARGIN = 2;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic rdy     = 1'b1;
    logic refresh = 1'b0;

    inst_queue_if iq_bus ();

    inst_queue #(
        .DEPTH       (DEPTH),
        .PTR_WIDTH   (4),
        .FULL_MARGIN (FULL_MARGIN)
    ) dut (
        .clk_in             (clk),
        .rst_in             (rst),
        .rdy_in             (rdy),
        .refresh_rob_cdb_in (refresh),
        .iq                 (iq_bus)
    );

    always #5 clk = ~clk;

    int        errors = 0;
    int        checks = 0;
    int        drops  = 0;
    bit        mon_en = 1'b0;
    iq_entry_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: the queue content is just an ordered list of accepted entries.
    always @(posedge clk) begin : model
        int n;
        bit do_pop;
        bit do_push;
        n = exp_q.size();
        if (rst || (refresh && rdy)) begin
            exp_q.delete();
        end else if (rdy) begin
            do_pop  = iq_bus.pop_dp_in && (n > 0);
            do_push = iq_bus.rdy_inst_if_in && (n < DEPTH);
            if (iq_bus.rdy_inst_if_in && n >= DEPTH) drops++;
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back('{inst: iq_bus.inst_if_in, pc: iq_bus.pc_if_in});
        end
    end

    always @(negedge clk) begin : monitor
        int n;
        if (mon_en) begin
            n = exp_q.size();
            check("valid", 64'(iq_bus.valid_dp_out), 64'(n != 0));
            check("full", 64'(iq_bus.iq_full_iq_out), 64'(n >= DEPTH - FULL_MARGIN));
            if (n != 0) begin
                check("head_pc", 64'(iq_bus.pc_dp_out), 64'(exp_q[0].pc));
                check("head_inst", 64'(iq_bus.inst_dp_out), 64'(exp_q[0].inst));
            end
        end
    end

    task automatic cyc(input bit push, input logic [31:0] pc, input logic [31:0] inst,
                       input bit pop, input bit r, input bit rf);
        iq_bus.rdy_inst_if_in = push;
        iq_bus.pc_if_in       = pc;
        iq_bus.inst_if_in     = inst;
        iq_bus.pop_dp_in      = pop;
        rdy                   = r;
        refresh               = rf;
        @(posedge clk);
        #1;
    endtask

    initial begin
        iq_bus.rdy_inst_if_in = 1'b0;
        iq_bus.pc_if_in       = '0;
        iq_bus.inst_if_in     = '0;
        iq_bus.pop_dp_in      = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        check("rst_valid", 64'(iq_bus.valid_dp_out), 64'd0);
        check("rst_full", 64'(iq_bus.iq_full_iq_out), 64'd0);
        check("rst_inst", 64'(iq_bus.inst_dp_out), 64'd0);
        check("rst_pc", 64'(iq_bus.pc_dp_out), 64'd0);
        rst = 1'b0;

        // Three pushes, no pops
        cyc(1, 32'h0, 32'h00000013, 0, 1, 0);
        check("first_push_valid", 64'(iq_bus.valid_dp_out), 64'd1);
        cyc(1, 32'h4, 32'h00100093, 0, 1, 0);
        cyc(1, 32'h8, 32'h00200113, 0, 1, 0);
        cyc(0, 32'h0, 32'h0, 0, 1, 0);
        cyc(0, 32'h0, 32'h0, 0, 1, 0);

        // Fill to 16; full must rise right after the 14th push
        for (int i = 3; i < 16; i++) begin
            cyc(1, 32'(i * 4), 32'h1000 + 32'(i), 0, 1, 0);
            if (i == 12) check("not_full_at_13", 64'(iq_bus.iq_full_iq_out), 64'd0);
            if (i == 13) check("full_at_14", 64'(iq_bus.iq_full_iq_out), 64'd1);
        end
        // 17th push must be dropped without disturbing contents
        cyc(1, 32'h40, 32'hdead, 0, 1, 0);

        // Drain while refilling: order 0x0..0x3C then 0x40.., pointers wrap
        cyc(0, 32'h0, 32'h0, 1, 1, 0);
        for (int i = 0; i < 20; i++) cyc(1, 32'h40 + 32'(i * 4), 32'h2000 + 32'(i), 1, 1, 0);

        // Flush with same-cycle push and pop
        cyc(0, 32'h0, 32'h0, 0, 1, 1);
        for (int i = 0; i < 5; i++) cyc(1, 32'h200 + 32'(i * 4), 32'h3000 + 32'(i), 0, 1, 0);
        cyc(1, 32'h100, 32'h77, 1, 1, 1);
        check("refresh_valid", 64'(iq_bus.valid_dp_out), 64'd0);
        check("refresh_full", 64'(iq_bus.iq_full_iq_out), 64'd0);
        cyc(1, 32'h100, 32'h77, 0, 1, 0);
        check("repush_pc", 64'(iq_bus.pc_dp_out), 64'h100);

        // Global stall with push and pop held high
        cyc(1, 32'h104, 32'h78, 0, 1, 0);
        cyc(1, 32'h108, 32'h79, 0, 1, 0);
        repeat (4) cyc(1, 32'h300, 32'h88, 1, 0, 0);
        cyc(1, 32'h300, 32'h88, 1, 1, 0);
        cyc(0, 32'h0, 32'h0, 0, 1, 0);
        check("after_stall_head", 64'(iq_bus.pc_dp_out), 64'h104);

        // Empty queue: push and pop together
        cyc(0, 32'h0, 32'h0, 0, 1, 1);
        cyc(1, 32'h500, 32'h99, 1, 1, 0);
        check("empty_pushpop_pc", 64'(iq_bus.pc_dp_out), 64'h500);
        cyc(0, 32'h0, 32'h0, 0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) < 60, $urandom, $urandom,
                $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 90,
                $urandom_range(0, 199) == 0);
        end
        cyc(0, 32'h0, 32'h0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
